// File: rtl/miss_ctrl_p_if.sv
// Signal bundle between the miss controller and its CPU, tag/data arrays and memory.
// The slave modport is the controller's view; master is the surrounding environment.
interface miss_ctrl_p_if;
  // CPU side
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_byte_enable256;
  logic        mem_resp;

  // Way status at the indexed set
  logic [23:0] tag0;
  logic [23:0] tag1;
  logic        valid0;
  logic        valid1;
  logic        dirty0;
  logic        dirty1;

  // Array control
  logic [1:0]  way_load;
  logic [1:0]  way_load_dirty;
  logic        way_dirty_in;
  logic [31:0] way_be0;
  logic [31:0] way_be1;
  logic        fill_sel;
  logic        wb_way;

  // Memory side
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic        pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_byte_enable256,
    input  tag0, tag1, valid0, valid1, dirty0, dirty1,
    input  pmem_resp,
    output mem_resp,
    output way_load, way_load_dirty, way_dirty_in, way_be0, way_be1, fill_sel, wb_way,
    output pmem_read, pmem_write, pmem_address
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_byte_enable256,
    output tag0, tag1, valid0, valid1, dirty0, dirty1,
    output pmem_resp,
    input  mem_resp,
    input  way_load, way_load_dirty, way_dirty_in, way_be0, way_be1, fill_sel, wb_way,
    input  pmem_read, pmem_write, pmem_address
  );
endinterface

// File: rtl/miss_ctrl_p.sv
// Miss controller for a 2-way, 8-set, 32-byte-line write-back cache with per-set LRU.
// Hits complete in IDLE; misses optionally write back the LRU victim, then refill it.
module miss_ctrl_p (
  input  logic         clk,
  input  logic         rst,
  miss_ctrl_p_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  lru_q, lru_d;
  logic        victim_q, victim_d;

  logic [23:0] req_tag;
  logic [2:0]  req_idx;
  logic        req_any;
  logic        hit0, hit1, hit;
  logic        hit_way;
  logic        miss_victim;
  logic        miss_needs_wb;
  logic [23:0] victim_tag;

  logic        mem_resp_o;
  logic [1:0]  way_load_o;
  logic [1:0]  way_load_dirty_o;
  logic        way_dirty_in_o;
  logic [31:0] way_be0_o;
  logic [31:0] way_be1_o;
  logic        fill_sel_o;
  logic        wb_way_o;
  logic        pmem_read_o;
  logic        pmem_write_o;
  logic [31:0] pmem_address_o;

  assign req_tag = bus.mem_address[31:8];
  assign req_idx = bus.mem_address[7:5];
  assign req_any = bus.mem_read | bus.mem_write;

  assign hit0    = bus.valid0 & (bus.tag0 == req_tag);
  assign hit1    = bus.valid1 & (bus.tag1 == req_tag);
  assign hit     = hit0 | hit1;
  // Way 0 wins when both ways report a hit.
  assign hit_way = ~hit0;

  assign miss_victim   = lru_q[req_idx];
  assign miss_needs_wb = miss_victim ? (bus.valid1 & bus.dirty1)
                                     : (bus.valid0 & bus.dirty0);
  // During write-back the tag array is still addressed by the pending request's index.
  assign victim_tag    = victim_q ? bus.tag1 : bus.tag0;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    if (rst) begin
      state_q  <= S_IDLE;
      // NOTE: lru is an 8-bit flop vector, not a RAM, so it is cleared with the
      // other state; a RAM-backed array would have no reset and need an init pass.
      lru_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lru_q    <= lru_d;
      victim_q <= victim_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d  = state_q;
    lru_d    = lru_q;
    victim_d = victim_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          if (hit) begin
            lru_d[req_idx] = ~hit_way;
          end else begin
            victim_d = miss_victim;
            state_d  = miss_needs_wb ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        if (bus.pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        if (bus.pmem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; held at zero while rst is asserted so a pmem_resp arriving in the
  // reset cycle cannot strobe the arrays.
  always_comb begin
    mem_resp_o       = 1'b0;
    way_load_o       = 2'b00;
    way_load_dirty_o = 2'b00;
    way_dirty_in_o   = 1'b0;
    way_be0_o        = '0;
    way_be1_o        = '0;
    fill_sel_o       = 1'b0;
    wb_way_o         = 1'b0;
    pmem_read_o      = 1'b0;
    pmem_write_o     = 1'b0;
    pmem_address_o   = '0;

    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_any && hit) begin
            mem_resp_o = 1'b1;
            // A simultaneous read and write is served as a write.
            if (bus.mem_write) begin
              if (hit_way) way_be1_o = bus.mem_byte_enable256;
              else         way_be0_o = bus.mem_byte_enable256;
              way_load_dirty_o[hit_way] = 1'b1;
              way_dirty_in_o            = 1'b1;
            end
          end
        end
        S_WB: begin
          pmem_write_o   = 1'b1;
          wb_way_o       = victim_q;
          pmem_address_o = {victim_tag, req_idx, 5'b0};
        end
        S_FILL: begin
          pmem_read_o    = 1'b1;
          pmem_address_o = {bus.mem_address[31:5], 5'b0};
          if (bus.pmem_resp) begin
            if (victim_q) way_be1_o = '1;
            else          way_be0_o = '1;
            fill_sel_o                 = 1'b1;
            way_load_o[victim_q]       = 1'b1;
            way_load_dirty_o[victim_q] = 1'b1;
            way_dirty_in_o             = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_resp       = mem_resp_o;
  assign bus.way_load       = way_load_o;
  assign bus.way_load_dirty = way_load_dirty_o;
  assign bus.way_dirty_in   = way_dirty_in_o;
  assign bus.way_be0        = way_be0_o;
  assign bus.way_be1        = way_be1_o;
  assign bus.fill_sel       = fill_sel_o;
  assign bus.wb_way         = wb_way_o;
  assign bus.pmem_read      = pmem_read_o;
  assign bus.pmem_write     = pmem_write_o;
  assign bus.pmem_address   = pmem_address_o;

  a_pmem_excl: assert property (@(posedge clk) !(pmem_read_o && pmem_write_o));
  a_resp_idle: assert property (@(posedge clk) mem_resp_o |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_miss_ctrl_p.sv
// Bench for miss_ctrl_p: models the tag/status arrays and memory around the controller
// and scores its array strobes, memory requests and CPU responses against a cache model.
module tb_miss_ctrl_p;

  logic clk;
  logic rst;

  miss_ctrl_p_if bus ();

  miss_ctrl_p dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {EV_WB, EV_FILL, EV_RESP} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic        way;
    logic        wr;
    logic [31:0] be;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference cache model (expected state)
  logic        m_valid [2][8];
  logic        m_dirty [2][8];
  logic [23:0] m_tag   [2][8];
  logic [7:0]  m_lru;

  // Environment arrays (driven into the DUT, updated by its strobes)
  logic        e_valid [2][8];
  logic        e_dirty [2][8];
  logic [23:0] e_tag   [2][8];

  assign bus.tag0   = e_tag[0][bus.mem_address[7:5]];
  assign bus.tag1   = e_tag[1][bus.mem_address[7:5]];
  assign bus.valid0 = e_valid[0][bus.mem_address[7:5]];
  assign bus.valid1 = e_valid[1][bus.mem_address[7:5]];
  assign bus.dirty0 = e_dirty[0][bus.mem_address[7:5]];
  assign bus.dirty1 = e_dirty[1][bus.mem_address[7:5]];

  int   fixed_delay = -1;
  logic force_resp  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [31:0] a, input logic w,
                         input logic wr, input logic [31:0] be);
    ev_t e;
    e.kind = k; e.addr = a; e.way = w; e.wr = wr; e.be = be;
    sb_q.push_back(e);
  endtask

  // Cache behaviour: hit picks lowest matching way; miss evicts LRU, writing back if dirty,
  // installs the line clean, then the request completes as a hit.
  task automatic model_req(input logic wr, input logic [31:0] a, input logic [31:0] be);
    logic [23:0] t;
    logic [2:0]  ix;
    logic        v;
    int          hw;
    t  = a[31:8];
    ix = a[7:5];
    hw = -1;
    if (m_valid[0][ix] && m_tag[0][ix] == t)      hw = 0;
    else if (m_valid[1][ix] && m_tag[1][ix] == t) hw = 1;
    if (hw < 0) begin
      v = m_lru[ix];
      if (m_valid[v][ix] && m_dirty[v][ix])
        push_ev(EV_WB, {m_tag[v][ix], ix, 5'b0}, v, 1'b0, '0);
      push_ev(EV_FILL, {a[31:5], 5'b0}, v, 1'b0, '0);
      m_valid[v][ix] = 1'b1;
      m_tag[v][ix]   = t;
      m_dirty[v][ix] = 1'b0;
      hw = int'(v);
    end
    push_ev(EV_RESP, '0, hw[0], wr, be);
    m_lru[ix] = (hw == 0);
    if (wr) m_dirty[hw][ix] = 1'b1;
  endtask

  task automatic preset(input int w, input int ix, input logic [23:0] t,
                        input logic vld, input logic drt);
    e_valid[w][ix] = vld; e_tag[w][ix] = t; e_dirty[w][ix] = drt;
    m_valid[w][ix] = vld; m_tag[w][ix] = t; m_dirty[w][ix] = drt;
  endtask

  task automatic handle(input ev_kind_e kind);
    ev_t        e;
    logic [1:0] oh;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_unexpected: got event %s, expected none queued", kind.name());
      return;
    end
    e  = sb_q.pop_front();
    oh = e.way ? 2'b10 : 2'b01;
    check("ev_kind", 64'(kind), 64'(e.kind));
    if (kind != e.kind) return;
    case (kind)
      EV_WB: begin
        check("wb_addr", 64'(bus.pmem_address), 64'(e.addr));
        check("wb_way", 64'(bus.wb_way), 64'(e.way));
      end
      EV_FILL: begin
        check("fill_addr", 64'(bus.pmem_address), 64'(e.addr));
        check("fill_load", 64'(bus.way_load), 64'(oh));
        check("fill_load_dirty", 64'(bus.way_load_dirty), 64'(oh));
        check("fill_dirty_in", 64'(bus.way_dirty_in), 64'd0);
        check("fill_sel", 64'(bus.fill_sel), 64'd1);
        check("fill_be0", 64'(bus.way_be0), e.way ? 64'd0 : 64'hFFFF_FFFF);
        check("fill_be1", 64'(bus.way_be1), e.way ? 64'hFFFF_FFFF : 64'd0);
      end
      default: begin
        check("resp_be0", 64'(bus.way_be0), (e.wr && !e.way) ? 64'(e.be) : 64'd0);
        check("resp_be1", 64'(bus.way_be1), (e.wr && e.way) ? 64'(e.be) : 64'd0);
        check("resp_load_dirty", 64'(bus.way_load_dirty), e.wr ? 64'(oh) : 64'd0);
        check("resp_dirty_in", 64'(bus.way_dirty_in), 64'(e.wr));
        check("resp_load", 64'(bus.way_load), 64'd0);
        check("resp_fill_sel", 64'(bus.fill_sel), 64'd0);
        check("resp_pmem_idle", 64'({bus.pmem_read, bus.pmem_write}), 64'd0);
      end
    endcase
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.pmem_read || bus.pmem_write)
          check("pmem_excl", 64'(bus.pmem_read & bus.pmem_write), 64'd0);
        if (bus.pmem_write && bus.pmem_resp) handle(EV_WB);
        if (bus.pmem_read && bus.pmem_resp)  handle(EV_FILL);
        if (bus.mem_resp)                    handle(EV_RESP);
      end
    end
  end

  // Environment: applies array strobes and answers memory requests after a delay.
  initial begin
    logic [1:0]  c_load, c_ld_dirty;
    logic        c_din;
    logic [23:0] c_tag;
    logic [2:0]  c_idx;
    logic        prev_rd, prev_wr, prev_resp, req_new;
    int          wait_cnt;
    c_load = '0; c_ld_dirty = '0; c_din = 1'b0; c_tag = '0; c_idx = '0;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_resp = 1'b0; wait_cnt = 0;
    bus.pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (prev_rd && !prev_resp) check("pmem_read_held", 64'(bus.pmem_read), 64'd1);
        if (prev_wr && !prev_resp) check("pmem_write_held", 64'(bus.pmem_write), 64'd1);
        c_load     = bus.way_load;
        c_ld_dirty = bus.way_load_dirty;
        c_din      = bus.way_dirty_in;
        c_tag      = bus.mem_address[31:8];
        c_idx      = bus.mem_address[7:5];
        prev_rd    = bus.pmem_read;
        prev_wr    = bus.pmem_write;
        prev_resp  = bus.pmem_resp;
      end else begin
        c_load = '0; c_ld_dirty = '0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_resp = 1'b0;
      end
      @(posedge clk);
      #2;
      for (int w = 0; w < 2; w++) begin
        if (c_load[w]) begin
          e_valid[w][c_idx] = 1'b1;
          e_tag[w][c_idx]   = c_tag;
        end
        if (c_ld_dirty[w]) e_dirty[w][c_idx] = c_din;
      end
      bus.pmem_resp = 1'b0;
      if (force_resp) begin
        bus.pmem_resp = 1'b1;
      end else if (!rst && (bus.pmem_read || bus.pmem_write)) begin
        req_new = !(prev_rd || prev_wr) || prev_resp;
        if (req_new) wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        if (wait_cnt == 0) bus.pmem_resp = 1'b1;
        else               wait_cnt--;
      end
    end
  end

  // Issue one CPU request at posedge+1, hold it until mem_resp, return latency in cycles.
  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] be, output int lat);
    model_req(wr, a, be);
    bus.mem_read           = rd;
    bus.mem_write          = wr;
    bus.mem_address        = a;
    bus.mem_byte_enable256 = be;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.mem_resp && lat < 300);
    if (!bus.mem_resp) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: no mem_resp after %0d cycles for address 0x%08h", lat, a);
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    check("lru", 64'(dut.lru_q), 64'(m_lru));
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_byte_enable256 = '0;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        e_valid[w][i] = 1'b0; e_dirty[w][i] = 1'b0; e_tag[w][i] = '0;
        m_valid[w][i] = 1'b0; m_dirty[w][i] = 1'b0; m_tag[w][i] = '0;
      end
    end
    m_lru = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_resp", 64'(bus.mem_resp), 64'd0);
    check("rst_pmem_read", 64'(bus.pmem_read), 64'd0);
    check("rst_pmem_write", 64'(bus.pmem_write), 64'd0);
    check("rst_way_load", 64'(bus.way_load), 64'd0);
    check("rst_pmem_addr", 64'(bus.pmem_address), 64'd0);
    check("rst_lru", 64'(dut.lru_q), 64'd0);
    @(posedge clk);
    #1;

    // Cold read miss at index 1 fills way 0; latency 1 + 1 + 1
    fixed_delay = 0;
    cpu_req(1'b1, 1'b0, 32'h0000_0120, '0, lat);
    check("cold_lat", 64'(lat), 64'd3);
    check("cold_lru", 64'(dut.lru_q), 64'h02);

    // Write hit on way 1
    preset(1, 2, 24'h000055, 1'b1, 1'b0);
    cpu_req(1'b0, 1'b1, {24'h000055, 3'd2, 5'd0}, 32'h0000_000F, lat);
    check("whit_lat", 64'(lat), 64'd1);

    // Dirty victim write-back then fill: 1 + 2 + 2 + 1
    preset(0, 3, 24'hABCDEF, 1'b1, 1'b1);
    preset(1, 3, 24'h000777, 1'b1, 1'b0);
    fixed_delay = 1;
    cpu_req(1'b1, 1'b0, {24'h123456, 3'd3, 5'd4}, '0, lat);
    check("wb_lat", 64'(lat), 64'd6);
    check("wb_installed_tag", 64'(e_tag[0][3]), 64'h123456);
    check("wb_installed_clean", 64'(e_dirty[0][3]), 64'd0);

    // Clean victim, fill answered after 5 wait cycles: 1 + 6 + 1
    preset(0, 4, 24'h000099, 1'b1, 1'b0);
    fixed_delay = 5;
    cpu_req(1'b1, 1'b0, {24'h004242, 3'd4, 5'd0}, '0, lat);
    check("slow_fill_lat", 64'(lat), 64'd8);

    // Both ways hit with read+write: way 0, write path
    preset(0, 5, 24'h000031, 1'b1, 1'b0);
    preset(1, 5, 24'h000031, 1'b1, 1'b0);
    fixed_delay = -1;
    cpu_req(1'b1, 1'b1, {24'h000031, 3'd5, 5'h1C}, 32'hF0F0_0000, lat);
    check("dual_hit_lat", 64'(lat), 64'd1);

    // Reset in the second write-back cycle with a coincident pmem_resp
    preset(0, 6, 24'h00DEAD, 1'b1, 1'b1);
    fixed_delay = 20;
    bus.mem_read    = 1'b1;
    bus.mem_address = {24'h00BEEF, 3'd6, 5'd0};
    @(negedge clk);
    check("abort_idle_cycle", 64'(bus.pmem_write), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_wb_cycle1", 64'(bus.pmem_write), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    force_resp = 1'b1;
    bus.mem_read = 1'b0;
    m_lru = '0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_resp = 1'b0;
    fixed_delay = -1;
    @(negedge clk);
    check("abort_pmem_write", 64'(bus.pmem_write), 64'd0);
    check("abort_lru", 64'(dut.lru_q), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_fill", 64'(bus.pmem_read), 64'd0);
    end
    check("abort_no_install", 64'(e_tag[0][6]), 64'h00DEAD);
    @(posedge clk);
    #1;

    // Randomized traffic over a small tag pool to force conflicts and evictions
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [31:0] a;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      op = int'($urandom_range(0, 2));
      a  = {24'h000100 + 24'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31))};
      cpu_req(op != 1, op != 0, a, $urandom, lat);
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/miss_ctrl_p.md
MISS_CTRL_P -- requirements
Module: miss_ctrl_p

Interface
REQ-001: Parameters: none; geometry fixed at 2 ways, 8 sets, 256-bit lines, address = tag[31:8] | index[7:5] | offset[4:0].
REQ-002: clk  in  1  single clock; all state updates on rising edge.
REQ-003: rst  in  1  synchronous, active-high reset.
REQ-004: mem_read  in  1  CPU-side read request, held until mem_resp.
REQ-005: mem_write  in  1  CPU-side write request, held until mem_resp.
REQ-006: mem_address  in  32  CPU request address.
REQ-007: mem_byte_enable256  in  32  per-byte write enables for the addressed line.
REQ-008: mem_resp  out  1  one-cycle completion pulse to CPU.
REQ-009: tag0, tag1  in  24 each  stored tags of way 0/1 at mem_address index.
REQ-010: valid0, valid1, dirty0, dirty1  in  1 each  way status bits at mem_address index.
REQ-011: way_load  out  2  per-way valid/tag load strobe.
REQ-012: way_load_dirty  out  2  per-way dirty-bit load strobe.
REQ-013: way_dirty_in  out  1  value written to a dirty bit when way_load_dirty is set.
REQ-014: way_be0, way_be1  out  32 each  per-way data-array byte write enables.
REQ-015: fill_sel  out  1  data mux select: 0 = CPU write data, 1 = pmem line.
REQ-016: wb_way  out  1  selects which way's line drives pmem write data.
REQ-017: pmem_read, pmem_write  out  1 each  memory-side line requests, held until pmem_resp.
REQ-018: pmem_address  out  32  line-aligned memory address (bits [4:0] = 0).
REQ-019: pmem_resp  in  1  memory-side one-cycle completion.

Function
REQ-020: FSM states IDLE, WB, FILL; all outputs default 0 in every state unless stated.
REQ-021: hit_w = valid_w AND (tag_w == mem_address[31:8]); if both ways hit, way 0 is used.
REQ-022: IDLE, read hit: mem_resp=1 in the same cycle; lru[index] <= other way; stay IDLE.
REQ-023: IDLE, write hit on way w: way_bew=mem_byte_enable256, fill_sel=0, way_load_dirty[w]=1, way_dirty_in=1, mem_resp=1, lru[index] <= other way.
REQ-024: Both mem_read and mem_write high is treated as a write.
REQ-025: IDLE, miss: victim v = lru[index], latched in a register; if valid_v AND dirty_v -> WB, else -> FILL; mem_resp=0.
REQ-026: WB: pmem_write=1, wb_way=v, pmem_address={tag_v, index, 5'b0}; on pmem_resp -> FILL, else stay.
REQ-027: FILL: pmem_read=1, pmem_address={mem_address[31:5], 5'b0}; on pmem_resp: way_bev=32'hFFFF_FFFF, fill_sel=1, way_load[v]=1, way_load_dirty[v]=1, way_dirty_in=0, -> IDLE.
REQ-028: After FILL the request is served as a hit from IDLE on the following cycle; miss latency = 1 (IDLE) + WB cycles + FILL cycles + 1.
REQ-029: pmem_read and pmem_write are never asserted together; mem_resp is asserted only in IDLE.
REQ-030: CPU request deasserted during WB/FILL: the sequence still completes and the line is installed; no mem_resp is issued.
REQ-031: lru is 8x1 bits, updated only on hits.

Reset
REQ-032: rst in any state (including mid-WB/FILL) forces IDLE, lru all 0, victim register 0, all outputs 0 on the next edge; a pending pmem_resp is ignored.

Verification
REQ-033: After reset, read 0x0000_0120, all invalid -> FILL at pmem_address 0x0000_0120, way 0 loaded, mem_resp 1 cycle after the FILL pmem_resp, lru[1]=1.
REQ-034: Write hit, way 1, be=0x0000_000F -> way_be1=0x0000_000F, way_load_dirty=2'b10, way_dirty_in=1, mem_resp in the same cycle.
REQ-035: Miss, victim valid+dirty tag 0xABCDEF, index 3 -> WB with pmem_address 0xABCDEF60, wb_way=victim, then FILL with the new tag; way_dirty_in=0 on install.
REQ-036: Miss, victim clean -> no pmem_write, direct FILL; pmem_read held across a 5-cycle pmem_resp delay.
REQ-037: rst asserted in the 2nd WB cycle -> IDLE, pmem_write=0 next cycle, lru all 0.
REQ-038: Both ways hit -> way 0 selected; mem_read+mem_write both set -> write path taken.
